dbus_uart_tx: RTL

- Drains bytes received by the DBUS link endpoint and sends them to the host as 8N1 UART frames.
- Forms the DBUS-to-host half of the link/UART bridge.
- Reads through the endpoint's receive handshake (data/avail/read) into a small FIFO, then serializes LSB-first on a single TX line.
- Runs entirely in the link clock domain.

---
 rtl/dbus_uart_tx_pkg.sv | 19 +
 rtl/dbus_uart_tx_if.sv | 20 ++
 rtl/dbus_uart_tx_byte_fifo.sv | 61 ++++++
 rtl/dbus_uart_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dbus_uart_tx_pkg.sv
// Shared types and constants for the DBUS <-> host UART bridge.
package dbus_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 217;

    typedef enum logic {
        R_IDLE,
        R_WAITCLR
    } rd_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

endpackage

// File: rtl/dbus_uart_tx_if.sv
// Receive handshake of the DBUS link endpoint: byte, byte-waiting flag, one-cycle acknowledge.
interface dbus_uart_tx_if;

    logic [7:0] data;
    logic       avail;
    logic       read;

    modport master (
        output data,
        output avail,
        input  read
    );

    modport slave (
        input  data,
        input  avail,
        output read
    );

endinterface

// File: rtl/dbus_uart_tx_byte_fifo.sv
// Byte FIFO with first-word-fall-through head and occupancy count; shared with the UART RX path.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic [4:0] o_count,
    output logic       o_full,
    output logic       o_empty
);

    localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // Guards keep the pointers coherent even if a caller ignores full/empty.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == 5'd0);

endmodule

// File: rtl/dbus_uart_tx.sv
// DBUS-to-host bridge half: drains endpoint bytes into a FIFO and sends them as 8N1 UART frames.
//
// state      | meaning
// R_IDLE     | waiting for a byte at the endpoint and room in the FIFO
// R_WAITCLR  | byte taken; waiting for the endpoint to drop avail
// T_IDLE     | line high; pops the FIFO head when one is present
// T_START    | start bit (low)
// T_DATA     | data bits, LSB first
// T_STOP     | stop bit (high)
module dbus_uart_tx
    import dbus_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    dbus_uart_tx_if.slave      bus,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_fifo_full,
    output logic [4:0]         o_fifo_count
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);

    rd_state_t   r_rd_state;
    rd_state_t   w_rd_state_nxt;
    logic        r_read;
    logic        w_push;

    tx_state_t   r_tx_state;
    tx_state_t   w_tx_state_nxt;
    logic [15:0] r_baud;
    logic [15:0] w_baud_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_nxt;
    logic [7:0]  r_tx_byte;
    logic [7:0]  w_tx_byte_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_pop;

    logic [7:0]  w_fifo_data;
    logic [4:0]  w_fifo_count;
    logic        w_fifo_full;
    logic        w_fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (w_push),
        .i_data    (bus.data),
        .i_pop     (w_pop),
        .o_data    (w_fifo_data),
        .o_count   (w_fifo_count),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Reader: one push per avail assertion; the endpoint drops avail two cycles after read.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_push         = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (bus.avail && !w_fifo_full) begin
                    w_push         = 1'b1;
                    w_rd_state_nxt = R_WAITCLR;
                end
            end
            R_WAITCLR: begin
                if (!bus.avail) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_state <= R_IDLE;
            r_read     <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_read     <= w_push;
        end
    end

    assign bus.read = r_read;

    // Serializer: the baud counter is held at reload in T_IDLE so every bit starts from a full period.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_baud_nxt     = (r_baud != 16'd0) ? (r_baud - 16'd1) : 16'd0;
        w_bit_idx_nxt  = r_bit_idx;
        w_tx_byte_nxt  = r_tx_byte;
        w_pop          = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                w_baud_nxt = BAUD_RELOAD;
                if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_tx_byte_nxt  = w_fifo_data;
                    w_bit_idx_nxt  = 3'd0;
                    w_tx_state_nxt = T_START;
                end
            end
            T_START: begin
                if (r_baud == 16'd0) begin
                    w_baud_nxt     = BAUD_RELOAD;
                    w_bit_idx_nxt  = 3'd0;
                    w_tx_state_nxt = T_DATA;
                end
            end
            T_DATA: begin
                if (r_baud == 16'd0) begin
                    w_baud_nxt = BAUD_RELOAD;
                    if (r_bit_idx == LAST_BIT) begin
                        w_tx_state_nxt = T_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            T_STOP: begin
                if (r_baud == 16'd0) begin
                    w_baud_nxt     = BAUD_RELOAD;
                    w_tx_state_nxt = T_IDLE;
                end
            end
            default: w_tx_state_nxt = T_IDLE;
        endcase

        // Line level is registered alongside the state so o_tx is glitch-free.
        case (w_tx_state_nxt)
            T_START: w_tx_nxt = 1'b0;
            T_DATA:  w_tx_nxt = w_tx_byte_nxt[w_bit_idx_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_state <= T_IDLE;
            r_baud     <= BAUD_RELOAD;
            r_bit_idx  <= 3'd0;
            r_tx_byte  <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign o_tx         = r_tx;
    assign o_busy       = (r_tx_state != T_IDLE);
    assign o_fifo_full  = w_fifo_full;
    assign o_fifo_count = w_fifo_count;

endmodule
